// File: rtl/fifo_skid_wr.sv
// Write-side adapter: valid/ready stream into the synchronous fifo write port through a 2-entry skid buffer.
// Optional zero-latency bypass when empty: define FIFO_SKID_WR_BYPASS_EN.
module fifo_skid_wr #(
   parameter int DATA_WIDTH = 0,
   localparam int unsigned DW = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          wr_en,
   output logic [DW-1:0] wr_data,
   input  logic          full,
   output logic [1:0]    occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] head;
   logic [DW-1:0] skid;
   logic          push;
   logic          pop;
   logic          bypass;

   // Readiness depends only on the occupancy register, never on full.
   assign s_ready = (state != TWO) && !rst;
   assign push    = s_valid && s_ready;
   assign occ     = 2'(state);

`ifdef FIFO_SKID_WR_BYPASS_EN
   // Empty and FIFO not full: the incoming word goes straight through unstored.
   assign bypass  = (state == EMPTY) && !full && !rst;
   assign wr_en   = bypass ? s_valid : ((state != EMPTY) && !full && !rst);
   assign wr_data = bypass ? s_data : head;
`else
   assign bypass  = 1'b0;
   assign wr_en   = (state != EMPTY) && !full && !rst;
   assign wr_data = head;
`endif

   assign pop = wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push && !bypass) begin
                  head  <= s_data;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid  <= s_data;
                  state <= TWO;
               end else if (push && pop) begin
                  head <= s_data;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_skid_wr.sv
// Directed and randomised bench for fifo_skid_wr with a scoreboard on the FIFO write port.
module tb_fifo_skid_wr;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic         wr_en;
   logic [W-1:0] wr_data;
   logic         full;
   logic [1:0]   occ;

   int n_cmp  = 0;
   int n_bad  = 0;
   int wr_cnt = 0;
   logic [W-1:0] q[$];

   fifo_skid_wr #(.DATA_WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .occ     (occ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted words in, FIFO writes out, in order.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (s_valid && s_ready) q.push_back(s_data);
         if (wr_en) begin
            wr_cnt++;
            check("wr_while_full", 32'(full), 32'd0);
            if (q.size() == 0) check("wr_extra", 32'(wr_en), 32'd0);
            else check("wr_order", 32'(wr_data), 32'(q.pop_front()));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_we;
      logic acc;
      int   sent;
      int   wr0;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_occ", 32'(occ), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      next();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd1);
      next();

      // Stream 0x01..0x10 with full low.
      for (int k = 0; k < 18; k++) begin
         s_valid = (k < 16);
         s_data  = W'(k + 1);
         @(negedge clk);
`ifdef FIFO_SKID_WR_BYPASS_EN
         exp_we = (k <= 15);
         check("stream_occ", 32'(occ), 32'd0);
         if (exp_we) check("stream_data", 32'(wr_data), 32'(k + 1));
`else
         exp_we = (k >= 1) && (k <= 16);
         check("stream_occ", 32'(occ), (k >= 1 && k <= 16) ? 32'd1 : 32'd0);
         if (exp_we) check("stream_data", 32'(wr_data), 32'(k));
`endif
         check("stream_wr_en", 32'(wr_en), 32'(exp_we));
         if (k < 16) check("stream_s_ready", 32'(s_ready), 32'd1);
         next();
      end

      // full high absorbs two words then stalls upstream.
      s_valid = 1'b1; full = 1'b1; s_data = 8'hA1;
      @(negedge clk);
      check("full_a1_wr_en", 32'(wr_en), 32'd0);
      check("full_a1_ready", 32'(s_ready), 32'd1);
      next();
      s_data = 8'hA2;
      @(negedge clk);
      check("full_a2_occ", 32'(occ), 32'd1);
      check("full_a2_wr_en", 32'(wr_en), 32'd0);
      check("full_a2_ready", 32'(s_ready), 32'd1);
      next();
      s_data = 8'hA3;
      repeat (2) begin
         @(negedge clk);
         check("full_hold_occ", 32'(occ), 32'd2);
         check("full_hold_ready", 32'(s_ready), 32'd0);
         check("full_hold_wr_en", 32'(wr_en), 32'd0);
         next();
      end
      full = 1'b0;
      @(negedge clk);
      check("rel_a1_wr_en", 32'(wr_en), 32'd1);
      check("rel_a1_data", 32'(wr_data), 32'hA1);
      check("rel_a1_ready", 32'(s_ready), 32'd0);
      next();
      @(negedge clk);
      check("rel_a2_wr_en", 32'(wr_en), 32'd1);
      check("rel_a2_data", 32'(wr_data), 32'hA2);
      check("rel_a2_ready", 32'(s_ready), 32'd1);
      next();
      s_valid = 1'b0;
      @(negedge clk);
      check("rel_a3_wr_en", 32'(wr_en), 32'd1);
      check("rel_a3_data", 32'(wr_data), 32'hA3);
      next();
      @(negedge clk);
      check("rel_idle_wr_en", 32'(wr_en), 32'd0);
      check("rel_idle_occ", 32'(occ), 32'd0);
      next();

      // full toggling every cycle, 64 incrementing words.
      sent = 0;
      wr0  = wr_cnt;
      for (int c = 0; c < 400 && sent < 64; c++) begin
         s_valid = 1'b1;
         s_data  = W'(sent);
         full    = (c % 2) == 1;
         @(negedge clk);
         acc = s_valid && s_ready;
         next();
         if (acc) sent++;
      end
      s_valid = 1'b0; full = 1'b0;
      for (int c = 0; c < 10 && q.size() != 0; c++) begin
         @(negedge clk);
         next();
      end
      check("tog_sent", 32'(sent), 32'd64);
      check("tog_written", 32'(wr_cnt - wr0), 32'd64);
      check("tog_drained", 32'(q.size()), 32'd0);

      // Reset while holding two words.
      full = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
      @(negedge clk);
      next();
      s_data = 8'hC2;
      @(negedge clk);
      next();
      @(negedge clk);
      check("pre_rst_occ", 32'(occ), 32'd2);
      next();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", 32'(s_ready), 32'd0);
      check("mid_rst_wr_en", 32'(wr_en), 32'd0);
      next();
      rst = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      check("after_rst_occ", 32'(occ), 32'd0);
      check("after_rst_wr_en", 32'(wr_en), 32'd0);
      check("after_rst_ready", 32'(s_ready), 32'd1);
      next();
      full = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_wr_en", 32'(wr_en), 32'd0);
         next();
      end

      // Randomised valid/full traffic.
      wr0 = wr_cnt;
      for (int c = 0; c < 10000; c++) begin
         s_valid = 1'($urandom_range(0, 1));
         full    = ($urandom_range(0, 3) == 0);
         s_data  = W'($urandom);
         @(negedge clk);
         next();
      end
      s_valid = 1'b0; full = 1'b0;
      for (int c = 0; c < 10 && q.size() != 0; c++) begin
         @(negedge clk);
         next();
      end
      check("rand_drained", 32'(q.size()), 32'd0);
      check("rand_idle_occ", 32'(occ), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_skid_wr.md
# fifo_skid_wr

Write-side adapter for the team's synchronous `fifo`: it accepts a valid/ready stream and drives the FIFO's `wr_en`/`din`/`full` port. It is the producer-end counterpart of `fifo_fwft`, which turns the FIFO read port into a valid/empty stream. A 2-entry skid buffer keeps `s_ready` free of any combinational path from `full`, so upstream logic can run at full rate without timing through the FIFO flags.

## Interface
- `DATA_WIDTH`, 0, data width in bits; the instantiating design must set it to 1 or more.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  DATA_WIDTH  upstream data.
- `s_valid`  in  1  upstream data valid.
- `s_ready`  out  1  adapter can accept; a transfer occurs when `s_valid & s_ready`.
- `wr_en`  out  1  write strobe to the FIFO; connects to FIFO `wr_en`.
- `wr_data`  out  DATA_WIDTH  write data to the FIFO; connects to FIFO `din`.
- `full`  in  1  FIFO full flag; connects to FIFO `full`.
- `occ`  out  2  skid occupancy, 0..2.

## Operation
- Storage is two registers:
  - `head` is the word currently presented on `wr_data`.
  - `skid` is the second word.
- The state machine is the occupancy `occ`, with states EMPTY (0), ONE (1) and TWO (2).
- `push = s_valid & s_ready`.
- `pop = wr_en`.
- `wr_en = (occ != 0) & !full`. `wr_en` is never asserted while `full` is high, so every `wr_en` pulse is a completed FIFO write.
- `s_ready = (occ != 2) & !rst`. It is a function of registered state only, plus the reset gate.
- Transitions and data moves:
  - EMPTY, push: `head <= s_data`, go to ONE.
  - ONE, push with no pop: `skid <= s_data`, go to TWO.
  - ONE, push and pop: `head <= s_data`, stay in ONE.
  - ONE, pop with no push: go to EMPTY.
  - TWO, pop: `head <= skid`, go to ONE. No push is possible in TWO because `s_ready` is 0.
  - No push and no pop: hold.
- Ordering: words reach the FIFO in exactly the order they were accepted. There is no loss and no duplication.
- `full` held high: the adapter absorbs at most 2 words, then deasserts `s_ready` until `full` falls.

## Timing
- Reset values: `occ` = 0, `wr_en` = 0, `s_ready` = 0 during every cycle `rst` is high, `head` = `skid` = 0, `wr_data` = 0.
- First cycle after `rst` falls: `s_ready` = 1.
- Latency, default build: a word accepted at edge N appears with `wr_en` = 1 in cycle N+1, provided `full` = 0.
- Throughput: 1 word per cycle sustained while `full` = 0.
- When `full` rises in cycle N, `wr_en` is 0 in cycle N, because the path from `full` to `wr_en` is combinational.
- When `full` falls, `wr_en` returns in the same cycle if `occ` > 0.
- Reset mid-operation: buffered words are discarded, `occ` returns to 0, and no `wr_en` is issued during reset.
- `s_valid` may toggle freely. Data is sampled only on a transfer.

## Configuration
- `FIFO_SKID_WR_BYPASS_EN` defined:
  - In EMPTY with `full` = 0, `wr_en = s_valid` and `wr_data = s_data`, combinationally. This gives zero-cycle latency.
  - The bypassed word is not stored and `occ` stays 0.
  - If `full` = 1 in EMPTY, a push is stored in `head` as normal.
  - This mode adds a combinational path from `s_valid`/`s_data` to `wr_en`/`wr_data`.
- `FIFO_SKID_WR_BYPASS_EN` undefined:
  - Fully registered behaviour as specified above.
  - `wr_en` and `wr_data` depend only on registered state and `full`.

## Test plan
- Reset, then stream 0x01..0x10 with `s_valid` = 1 and `full` = 0:
  - `s_ready` stays 1.
  - `wr_en` is 1 on 16 consecutive cycles starting 1 cycle after the first accept (0 cycles in bypass).
  - `wr_data` is 0x01..0x10 in order.
  - `occ` is at most 1.
- Accept 0xA1, then force `full` = 1 while offering 0xA2 and 0xA3:
  - 0xA2 is accepted and `occ` = 2.
  - `s_ready` = 0, so 0xA3 is held off.
  - `wr_en` = 0 throughout.
  - Release `full`: writes are 0xA1, 0xA2, 0xA3 on consecutive cycles.
- Toggle `full` every cycle under continuous `s_valid` with 64 incrementing words:
  - The FIFO receives all 64 words in order.
  - `wr_en` is never 1 while `full` = 1.
- Fill to `occ` = 2 with `full` = 1, then assert `rst` for 1 cycle:
  - `occ` = 0 and `wr_en` = 0.
  - `s_ready` is 0 during reset and 1 on the next cycle.
  - No stale words are written after `full` falls.
- Randomised `s_valid`/`full` over 10000 cycles with a scoreboard against the FIFO input: no loss, reorder or duplication, in both build configurations.
